regfile_dump_tx: RTL and testbench
==================================

Name: regfile_dump_tx

Overview:
- Debug readout engine for the single-cycle CPU register file.
- On a start pulse it walks register indices 0..NUM_REGS-1 through a spare read port (address out, combinational data back) and snapshots each value.
- It emits each register as a framed byte stream over a valid/ready interface. The stream feeds the board UART transmitter or a display scanner.
- It is the consumer end of the register file read interface; it never writes registers.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of registers dumped; must satisfy 1 <= NUM_REGS <= 2**ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin a dump; sampled only in IDLE.
- rd_addr  out  ADDR_W  register index presented to the register file read port.
- rd_data  in  DATA_W  combinational read data for rd_addr.
- tx_valid  out  1  byte available on tx_data.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready at posedge.
- tx_data  out  8  stream byte.
- busy  out  1  high in LOAD and SEND.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, rd_addr=0, idx=0, byte_cnt=0, snapshot=0, tx_valid=0, tx_data=0, busy=0, done=0. Reset asserted mid-dump aborts immediately; no partial frame is resumed after release.
- Frame per register: 1 + DATA_W/8 bytes, sent in this order:
  - byte 0 = index, zero-extended to 8 bits.
  - bytes 1.. = snapshot, MSB byte first. Default values: 5 bytes, 160 bytes per dump.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - busy=0, tx_valid=0.
  - start=1 at posedge -> LOAD, idx=0, rd_addr=0.
- LOAD (exactly 1 cycle):
  - rd_addr=idx.
  - At the posedge, capture snapshot<=rd_data, byte_cnt<=0, go to SEND.
  - The register file writes on negedge, so the posedge capture sees a stable value.
  - Each register is captured once. Later writes to it during its SEND do not alter the frame.
- SEND:
  - tx_valid=1; tx_data is selected by byte_cnt from the registered index and snapshot.
  - Handshake (tx_valid && tx_ready):
    - byte_cnt < DATA_W/8: byte_cnt++.
    - Otherwise, if idx == NUM_REGS-1: go to DONE.
    - Otherwise: idx++, rd_addr<=idx+1, go to LOAD.
  - tx_ready low: hold tx_valid=1 and tx_data stable, with no change to any state.
  - tx_valid is never dropped before acceptance.
- DONE: done=1 for exactly one cycle, busy=0, tx_valid=0, then go to IDLE.
- start while busy or in DONE: ignored, not queued. start held high continuously causes back-to-back dumps, one IDLE cycle between them.
- Latency:
  - start at posedge k -> LOAD during cycle k+1 -> first tx_valid after posedge k+1.
  - With tx_ready tied high, each register takes 1 + (1 + DATA_W/8) cycles (6 at defaults). A full default dump is 192 cycles from LOAD entry to the last handshake; done is asserted in the following cycle.
- Index wrap: idx never exceeds NUM_REGS-1; no modulo arithmetic is used. byte_cnt width is clog2(DATA_W/8 + 1).

Decomposition:
- Shared package (cpu_debug_pkg):
  - FSM state encoding (2-bit localparams IDLE/LOAD/SEND/DONE).
  - Frame-length constant BYTES_PER_REG = 1 + DATA_W/8.
- One natural sub-module, regfile_dump_byte_sel: a combinational mux from {idx, snapshot, byte_cnt} to tx_data. Everything else stays in the top FSM.

Test Plan:
- Sink always ready; registers preloaded r[i] = 32'h1000_0000 + i; pulse start -> 160 bytes. Register 3's frame is 03,10,00,00,03. done pulses exactly once, at cycle 193 after LOAD entry; busy falls with it.
- Sink ready toggles with a 1-of-3 duty cycle -> byte sequence is identical to the previous test. tx_data and tx_valid are stable across every stalled cycle, with no duplicated or dropped bytes.
- CPU writes r5 = 32'hDEAD_BEEF on the negedge after r5 is captured -> frame 5 carries the old value. Writing r6 before its LOAD cycle -> frame 6 carries DE,AD,BE,EF.
- start pulsed repeatedly mid-dump -> ignored; exactly 160 bytes and one done pulse. start held high -> second dump begins after done plus one IDLE cycle.
- resetn driven low mid-SEND (during the byte-2 stall of register 9) -> tx_valid=0, busy=0, rd_addr=0 immediately, with no clock required. After release, a new start restarts at index 0.
- NUM_REGS=4 override -> 20 bytes, last frame index 03, then done.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug readout blocks: dump FSM encoding and
// frame-geometry helpers derived from the register width.
package cpu_debug_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES_PER_REG  = 1 + DEFAULT_DATA_W / 8;

    // Frame length for an arbitrary register width: index byte plus data bytes.
    function automatic int bytes_per_reg(input int data_w);
        return 1 + data_w / 8;
    endfunction

    // byte_cnt must count 0..DATA_W/8 inclusive.
    function automatic int byte_cnt_w(input int data_w);
        return $clog2(data_w / 8 + 1);
    endfunction

endpackage

// File: rtl/regfile_dump_byte_sel.sv
// Frame byte selector: byte 0 is the register index, bytes 1.. are the
// snapshot, most significant byte first.
module regfile_dump_byte_sel
    import cpu_debug_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = byte_cnt_w(DATA_W)
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] snapshot,
    input  logic [CNT_W-1:0]  byte_cnt,
    output logic [7:0]        tx_data
);

    localparam int DATA_BYTES = DATA_W / 8;

    always_comb begin
        tx_data = 8'h00;
        if (byte_cnt == '0) begin
            tx_data = 8'(idx);
        end else begin
            for (int i = 1; i <= DATA_BYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) begin
                    tx_data = snapshot[(DATA_BYTES - i) * 8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump engine: walks every register through a spare read port,
// snapshots it, and streams an {index, data MSB-first} frame per register.
module regfile_dump_tx
    import cpu_debug_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int                DATA_BYTES = DATA_W / 8;
    localparam int                CNT_W      = byte_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(DATA_BYTES);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] snapshot_q, snapshot_d;
    logic [7:0]        sel_byte;
    logic              accept;
    logic              last_byte;
    logic              last_reg;

    // tx_valid is exactly "in SEND", so a handshake is SEND plus ready.
    assign accept    = (state_q == SEND) && tx_ready;
    assign last_byte = (byte_cnt_q == LAST_CNT);
    assign last_reg  = (idx_q == LAST_IDX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (accept && last_byte) begin
                    state_d = last_reg ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= '0;
            rd_addr_q  <= '0;
            byte_cnt_q <= '0;
            snapshot_q <= '0;
        end else begin
            idx_q      <= idx_d;
            rd_addr_q  <= rd_addr_d;
            byte_cnt_q <= byte_cnt_d;
            snapshot_q <= snapshot_d;
        end
    end

    // rd_addr is registered alongside idx so the read port sees a clean
    // address for the whole LOAD cycle; the register file writes on negedge.
    always_comb begin
        idx_d      = idx_q;
        rd_addr_d  = rd_addr_q;
        byte_cnt_d = byte_cnt_q;
        snapshot_d = snapshot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    rd_addr_d = '0;
                end
            end
            LOAD: begin
                snapshot_d = rd_data;
                byte_cnt_d = '0;
            end
            SEND: begin
                if (accept) begin
                    if (!last_byte) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end else if (!last_reg) begin
                        idx_d     = idx_q + 1'b1;
                        rd_addr_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    regfile_dump_byte_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_byte_sel (
        .idx      (idx_q),
        .snapshot (snapshot_q),
        .byte_cnt (byte_cnt_q),
        .tx_data  (sel_byte)
    );

    always_comb begin
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            LOAD: begin
                busy = 1'b1;
            end
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = sel_byte;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: register-file model, expected-byte scoreboard
// and a negedge monitor, plus a second instance with NUM_REGS=4.
module tb_regfile_dump_tx;

    localparam int DUMP_BYTES = 160;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    logic        start4 = 1'b0;
    logic [4:0]  rd_addr4;
    logic [31:0] rd_data4;
    logic        tx_valid4;
    logic        tx_ready4 = 1'b1;
    logic [7:0]  tx_data4;
    logic        busy4;
    logic        done4;

    logic [31:0] regs    [0:31];
    logic [31:0] exp_reg [0:31];

    logic [7:0]  exp_q[$];
    logic [7:0]  exp4_q[$];
    logic [7:0]  got  [0:511];
    logic [7:0]  got4 [0:63];

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int hs4_cnt = 0;
    int done4_cnt = 0;
    int ready_mode = 0;
    int stall_at = 0;
    int cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clock = ~clock;

    assign rd_data  = regs[rd_addr];
    assign rd_data4 = regs[rd_addr4];

    regfile_dump_tx dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done)
    );

    regfile_dump_tx #(.NUM_REGS(4)) dut4 (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start4),
        .rd_addr  (rd_addr4),
        .rd_data  (rd_data4),
        .tx_valid (tx_valid4),
        .tx_ready (tx_ready4),
        .tx_data  (tx_data4),
        .busy     (busy4),
        .done     (done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sink ready pattern, driven just after each posedge.
    always @(posedge clock) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = (hs_cnt != stall_at);
        endcase
    end

    always @(negedge clock) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %h expected none", tx_data);
                end else begin
                    check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                if (hs_cnt < 512) got[hs_cnt] = tx_data;
                hs_cnt++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) done_cnt++;
        end
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (tx_valid4) begin
                if (exp4_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte4: got %h expected none", tx_data4);
                end else begin
                    check("byte4", 32'(tx_data4), 32'(exp4_q.pop_front()));
                end
                if (hs4_cnt < 64) got4[hs4_cnt] = tx_data4;
                hs4_cnt++;
            end
            if (done4) done4_cnt++;
        end
    end

    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            regs[i]    = 32'h1000_0000 + i;
            exp_reg[i] = 32'h1000_0000 + i;
        end
    endtask

    task automatic push_dump(input int n, input bit to4);
        logic [7:0] b;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < 5; k++) begin
                b = (k == 0) ? 8'(r) : exp_reg[r][(4 - k) * 8 +: 8];
                if (to4) exp4_q.push_back(b);
                else     exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!done && c < 3000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
        end
    endtask

    task automatic end_of_dump(input string name, input int bytes, input int dones);
        repeat (4) @(negedge clock);
        check({name, "_bytes"}, 32'(hs_cnt), 32'(bytes));
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({name, "_dones"}, 32'(done_cnt), 32'(dones));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        logic [7:0] f3 [0:4];
        logic [7:0] f5 [0:4];
        logic [7:0] f6 [0:4];
        f3[0] = 8'h03; f3[1] = 8'h10; f3[2] = 8'h00; f3[3] = 8'h00; f3[4] = 8'h03;
        f5[0] = 8'h05; f5[1] = 8'h10; f5[2] = 8'h00; f5[3] = 8'h00; f5[4] = 8'h05;
        f6[0] = 8'h06; f6[1] = 8'hDE; f6[2] = 8'hAD; f6[3] = 8'hBE; f6[4] = 8'hEF;
        preload();

        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // Always-ready sink, full dump with timing of done.
        ready_mode = 0; hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        pulse_start();
        @(negedge clock);
        c = 1;
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(tx_valid), 32'd0);
        check("load_rd_addr", 32'(rd_addr), 32'd0);
        while (!done && c < 3000) begin
            @(negedge clock);
            c++;
        end
        check("done_cycle", 32'(c), 32'd193);
        check("done_busy", 32'(busy), 32'd0);
        end_of_dump("t1", DUMP_BYTES, 1);
        for (int i = 0; i < 5; i++) check("frame3", 32'(got[15 + i]), 32'(f3[i]));

        // One-in-three ready duty cycle.
        ready_mode = 1; hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        pulse_start();
        wait_done("t2");
        end_of_dump("t2", DUMP_BYTES, 1);

        // r5 written after capture, r6 written before its LOAD.
        ready_mode = 0; hs_cnt = 0; done_cnt = 0;
        exp_reg[6] = 32'hDEAD_BEEF;
        push_dump(32, 1'b0);
        pulse_start();
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!(rd_addr == 5'd5 && busy && !tx_valid) && c < 1000);
        check("r5_load_seen", 32'(rd_addr == 5'd5 && busy && !tx_valid), 32'd1);
        @(negedge clock);
        regs[5] = 32'hDEAD_BEEF;
        regs[6] = 32'hDEAD_BEEF;
        wait_done("t3");
        end_of_dump("t3", DUMP_BYTES, 1);
        for (int i = 0; i < 5; i++) check("frame5", 32'(got[25 + i]), 32'(f5[i]));
        for (int i = 0; i < 5; i++) check("frame6", 32'(got[30 + i]), 32'(f6[i]));
        preload();

        // Repeated start pulses while busy are ignored.
        hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        pulse_start();
        for (int p = 0; p < 8; p++) begin
            repeat (15) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
        end
        wait_done("t4");
        end_of_dump("t4", DUMP_BYTES, 1);

        // start held high: back-to-back dumps with one IDLE cycle between.
        hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        push_dump(32, 1'b0);
        @(posedge clock); #1 start = 1'b1;
        wait_done("t5a");
        @(negedge clock);
        check("gap_busy", 32'(busy), 32'd0);
        check("gap_valid", 32'(tx_valid), 32'd0);
        @(negedge clock);
        check("second_load_busy", 32'(busy), 32'd1);
        check("second_load_valid", 32'(tx_valid), 32'd0);
        @(posedge clock); #1 start = 1'b0;
        wait_done("t5b");
        end_of_dump("t5", 2 * DUMP_BYTES, 2);

        // Asynchronous reset during the byte-2 stall of register 9.
        ready_mode = 2; stall_at = 47; hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        pulse_start();
        c = 0;
        do begin
            @(posedge clock);
            #2;
            c++;
        end while (!(hs_cnt == 47 && !tx_ready) && c < 1000);
        check("stall_reached", 32'(hs_cnt), 32'd47);
        repeat (2) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'd0);
        check("arst_queue_left", 32'(exp_q.size()), 32'(DUMP_BYTES - 47));
        exp_q.delete();
        @(posedge clock); #1 resetn = 1'b1;
        ready_mode = 0; hs_cnt = 0; done_cnt = 0;
        push_dump(32, 1'b0);
        pulse_start();
        @(negedge clock);
        check("restart_rd_addr", 32'(rd_addr), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done("t6");
        end_of_dump("t6", DUMP_BYTES, 1);
        check("restart_first_idx", 32'(got[0]), 32'd0);

        // NUM_REGS=4 instance.
        hs4_cnt = 0; done4_cnt = 0;
        push_dump(4, 1'b1);
        @(posedge clock); #1 start4 = 1'b1;
        @(posedge clock); #1 start4 = 1'b0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!done4 && c < 500);
        check("n4_done_seen", 32'(done4), 32'd1);
        repeat (4) @(negedge clock);
        check("n4_bytes", 32'(hs4_cnt), 32'd20);
        check("n4_queue", 32'(exp4_q.size()), 32'd0);
        check("n4_last_idx", 32'(got4[15]), 32'h03);
        check("n4_dones", 32'(done4_cnt), 32'd1);
        check("n4_busy", 32'(busy4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
